mul_vec_outer_seq: RTL and testbench

- Parametrised, sequential successor to the fixed 2x2, 16-bit vector-multiply individuals.
- Computes the full outer product y[i*N+j] = a[i] * b[j] of two N-element vectors.
- Uses one time-shared multiplier stepped by a counter, with valid/ready handshakes on the input and output sides.
- Serves as the golden sequential baseline that evolved combinational individuals are scored against in the tournament harness.

---
 rtl/mul_vec_pkg.sv | 16 +
 rtl/mul_vec_lane.sv | 25 ++
 rtl/mul_vec_outer_seq.sv | 100 ++++++++++
 tb/tb_mul_vec_outer_seq.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mul_vec_pkg.sv
// Shared types and helpers for the sequential outer-product multiplier.
package mul_vec_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam int SAT_WRAP = 0;
   localparam int SAT_SAT  = 1;

   // Index counter width: clog2(N*N), but never narrower than one bit.
   function automatic int idx_w(input int n);
      int w;
      w = $clog2(n * n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/mul_vec_lane.sv
// One unsigned WIDTH x WIDTH multiply followed by wrap or saturate narrowing.
module mul_vec_lane
   import mul_vec_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SAT   = SAT_WRAP
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_p
);

   logic [2*WIDTH-1:0] w_full;

   function automatic logic [WIDTH-1:0] fit(input logic [2*WIDTH-1:0] p);
      if (SAT == SAT_SAT && |p[2*WIDTH-1:WIDTH]) begin
         return '1;
      end
      return p[WIDTH-1:0];
   endfunction

   assign w_full = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};
   assign o_p    = fit(w_full);

endmodule

// File: rtl/mul_vec_outer_seq.sv
// Outer product y[i*N+j] = a[i]*b[j], one product per cycle through a single shared lane.
module mul_vec_outer_seq
   import mul_vec_pkg::*;
#(
   parameter int N     = 2,
   parameter int WIDTH = 16,
   parameter int SAT   = SAT_WRAP
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [N*WIDTH-1:0]     a,
   input  logic [N*WIDTH-1:0]     b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [N*N*WIDTH-1:0]   y,
   output logic                   busy
);

   localparam int             NN     = N * N;
   localparam int             KW     = idx_w(N);
   localparam logic [KW-1:0]  K_LAST = KW'(NN - 1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [KW-1:0]       r_k;
   logic [N*WIDTH-1:0]  r_a;
   logic [N*WIDTH-1:0]  r_b;
   logic [NN*WIDTH-1:0] r_y;
   logic [KW-1:0]       w_i;
   logic [KW-1:0]       w_j;
   logic [WIDTH-1:0]    w_op_a;
   logic [WIDTH-1:0]    w_op_b;
   logic [WIDTH-1:0]    w_prod;
   logic                w_last;

   // k walks row-major: i selects the a element, j the b element.
   assign w_i    = KW'(int'(r_k) / N);
   assign w_j    = KW'(int'(r_k) % N);
   assign w_op_a = r_a[w_i*WIDTH +: WIDTH];
   assign w_op_b = r_b[w_j*WIDTH +: WIDTH];
   assign w_last = (r_k == K_LAST);

   mul_vec_lane #(
      .WIDTH (WIDTH),
      .SAT   (SAT)
   ) u_lane (
      .i_a (w_op_a),
      .i_b (w_op_b),
      .o_p (w_prod)
   );

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      busy        = 1'b0;
      out_valid   = 1'b0;
      unique case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_state_nxt = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (w_last) w_state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_k     <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_y     <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == IDLE && in_valid) begin
            r_a <= a;
            r_b <= b;
            r_k <= '0;
         end
         // Counter parks on the last index; the next accept re-zeroes it.
         if (r_state == RUN) begin
            r_y[r_k*WIDTH +: WIDTH] <= w_prod;
            if (!w_last) r_k <= r_k + KW'(1);
         end
      end
   end

   assign y = r_y;

endmodule

// File: tb/tb_mul_vec_outer_seq.sv
// Bench for mul_vec_outer_seq: three configurations, a cycle-level reference model and directed vectors.
module tb_mul_vec_outer_seq;

   logic clk;
   logic rst;

   logic        iv0, ir0, ov0, ordy0, bz0;
   logic [31:0] a0, b0;
   logic [63:0] y0;
   logic        iv1, ir1, ov1, ordy1, bz1;
   logic [31:0] a1, b1;
   logic [63:0] y1;
   logic        iv2, ir2, ov2, ordy2, bz2;
   logic [23:0] a2, b2;
   logic [71:0] y2;

   int n_checks = 0;
   int n_fail   = 0;

   mul_vec_outer_seq #(.N(2), .WIDTH(16), .SAT(0)) u0 (
      .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
      .out_valid(ov0), .out_ready(ordy0), .y(y0), .busy(bz0));
   mul_vec_outer_seq #(.N(2), .WIDTH(16), .SAT(1)) u1 (
      .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
      .out_valid(ov1), .out_ready(ordy1), .y(y1), .busy(bz1));
   mul_vec_outer_seq #(.N(3), .WIDTH(8), .SAT(0)) u2 (
      .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
      .out_valid(ov2), .out_ready(ordy2), .y(y2), .busy(bz2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: per instance, whether a transaction is outstanding and
   // how many edges have passed since it was accepted.
   bit             m_on    [3];
   bit             m_pend  [3];
   int             m_since [3];
   bit             m_yknown[3];
   logic [127:0]   m_y     [3];

   task automatic model_cycle(input int id, input int n, input int w, input int sat,
                              input logic iv, input logic ordy, input logic ir,
                              input logic ov, input logic bz, input logic rs,
                              input logic [127:0] av, input logic [127:0] bv,
                              input logic [127:0] yv);
      int nn;
      longint unsigned mask, ea, eb, p;
      logic [127:0] acc;
      nn   = n * n;
      mask = (64'd1 << w) - 64'd1;
      if (m_on[id]) begin
         check($sformatf("u%0d_in_ready", id), ir, !m_pend[id]);
         check($sformatf("u%0d_busy", id), bz, m_pend[id] && (m_since[id] < nn));
         check($sformatf("u%0d_out_valid", id), ov, m_pend[id] && (m_since[id] == nn));
         if (m_yknown[id]) check($sformatf("u%0d_y", id), yv, m_y[id]);
      end
      if (rs) begin
         m_on[id]     = 1'b1;
         m_pend[id]   = 1'b0;
         m_since[id]  = 0;
         m_yknown[id] = 1'b1;
         m_y[id]      = '0;
      end else if (m_on[id]) begin
         if (!m_pend[id]) begin
            if (iv) begin
               acc = '0;
               for (int k = 0; k < nn; k++) begin
                  ea = 64'(av >> ((k / n) * w)) & mask;
                  eb = 64'(bv >> ((k % n) * w)) & mask;
                  p  = ea * eb;
                  if (sat != 0 && p > mask) p = mask;
                  else p = p & mask;
                  acc = acc | (128'(p) << (k * w));
               end
               m_y[id]      = acc;
               m_pend[id]   = 1'b1;
               m_since[id]  = 0;
               m_yknown[id] = 1'b0;
            end
         end else if (m_since[id] < nn) begin
            m_since[id]++;
            if (m_since[id] == nn) m_yknown[id] = 1'b1;
         end else if (ordy) begin
            m_pend[id] = 1'b0;
         end
      end
   endtask

   always @(negedge clk) begin
      model_cycle(0, 2, 16, 0, iv0, ordy0, ir0, ov0, bz0, rst, 128'(a0), 128'(b0), 128'(y0));
      model_cycle(1, 2, 16, 1, iv1, ordy1, ir1, ov1, bz1, rst, 128'(a1), 128'(b1), 128'(y1));
      model_cycle(2, 3, 8, 0, iv2, ordy2, ir2, ov2, bz2, rst, 128'(a2), 128'(b2), 128'(y2));
   end

   task automatic wait_ov0(output int lat);
      lat = 0;
      while (!ov0 && lat < 30) begin
         step();
         lat++;
      end
      check("u0_out_valid_timeout", ov0, 1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  lat;
      int  busy_cnt;
      int  nov;
      int  t_ov [3];
      bit  ov_seen;

      rst = 1'b1;
      iv0 = 1'b0; ordy0 = 1'b0; a0 = '0; b0 = '0;
      iv1 = 1'b0; ordy1 = 1'b0; a1 = '0; b1 = '0;
      iv2 = 1'b0; ordy2 = 1'b0; a2 = '0; b2 = '0;
      t_ov = '{0, 0, 0};
      step();
      step();
      rst = 1'b0;
      check("rst_in_ready", ir0, 1'b1);
      check("rst_out_valid", ov0, 1'b0);
      check("rst_busy", bz0, 1'b0);
      check("rst_y", y0, 64'd0);
      check("rst_y_n3", y2, 72'd0);
      repeat (10) step();
      check("idle_in_ready", ir0, 1'b1);
      check("idle_busy", bz0, 1'b0);

      // Basic product, latency 4 for N=2
      a0 = {16'd5, 16'd3}; b0 = {16'd11, 16'd7};
      iv0 = 1'b1; step(); iv0 = 1'b0;
      wait_ov0(lat);
      check("basic_latency", lat, 4);
      check("basic_y", y0, {16'd55, 16'd35, 16'd33, 16'd21});
      ordy0 = 1'b1; step(); ordy0 = 1'b0;
      check("basic_release_ov", ov0, 1'b0);
      check("basic_release_ir", ir0, 1'b1);

      // Wrap versus saturate on the same operands
      a0 = {16'h00FF, 16'h0100}; b0 = {16'h0101, 16'h0100};
      a1 = a0; b1 = b0;
      iv0 = 1'b1; iv1 = 1'b1; step(); iv0 = 1'b0; iv1 = 1'b0;
      wait_ov0(lat);
      check("wrap_y", y0, {16'hFFFF, 16'hFF00, 16'h0100, 16'h0000});
      check("sat_ov", ov1, 1'b1);
      check("sat_y", y1, {16'hFFFF, 16'hFF00, 16'hFFFF, 16'hFFFF});
      ordy0 = 1'b1; ordy1 = 1'b1; step(); ordy0 = 1'b0; ordy1 = 1'b0;

      // Output backpressure
      a0 = {16'd3, 16'd2}; b0 = {16'd5, 16'd4};
      iv0 = 1'b1; step(); iv0 = 1'b0;
      wait_ov0(lat);
      repeat (20) step();
      check("bp_ov", ov0, 1'b1);
      check("bp_ir", ir0, 1'b0);
      check("bp_y", y0, {16'd15, 16'd12, 16'd10, 16'd8});
      ordy0 = 1'b1; step(); ordy0 = 1'b0;
      check("bp_release_ov", ov0, 1'b0);
      check("bp_release_ir", ir0, 1'b1);

      // Reset on the second RUN cycle
      a0 = {16'd5, 16'd3}; b0 = {16'd11, 16'd7};
      iv0 = 1'b1; step(); iv0 = 1'b0;
      step();
      rst = 1'b1; step(); rst = 1'b0;
      check("midrst_ir", ir0, 1'b1);
      check("midrst_busy", bz0, 1'b0);
      check("midrst_y", y0, 64'd0);
      ov_seen = 1'b0;
      repeat (8) begin
         if (ov0) ov_seen = 1'b1;
         step();
      end
      check("midrst_no_ov", ov_seen, 1'b0);
      a0 = {16'd2, 16'd1}; b0 = {16'd4, 16'd3};
      iv0 = 1'b1; step(); iv0 = 1'b0;
      wait_ov0(lat);
      check("after_rst_latency", lat, 4);
      check("after_rst_y", y0, {16'd8, 16'd6, 16'd4, 16'd3});
      ordy0 = 1'b1; step(); ordy0 = 1'b0;

      // N=3, WIDTH=8 back-to-back with valid and ready held high
      a2 = {8'd3, 8'd2, 8'd1}; b2 = {8'd6, 8'd5, 8'd4};
      iv2 = 1'b1; ordy2 = 1'b1; step();
      busy_cnt = 0;
      nov = 0;
      for (int c = 0; c < 60 && nov < 3; c++) begin
         if (nov == 0 && bz2) busy_cnt++;
         if (ov2) begin
            if (nov == 0)
               check("n3_y", y2, {8'd18, 8'd15, 8'd12, 8'd12, 8'd10, 8'd8, 8'd6, 8'd5, 8'd4});
            t_ov[nov] = c;
            nov++;
         end
         if (nov < 3) step();
      end
      iv2 = 1'b0; step(); ordy2 = 1'b0;
      check("n3_results", nov, 3);
      check("n3_busy_cycles", busy_cnt, 9);
      check("n3_period_a", t_ov[1] - t_ov[0], 11);
      check("n3_period_b", t_ov[2] - t_ov[1], 11);
      check("n3_idle_after", ir2, 1'b1);

      repeat (3) step();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
